clk_div_scheduler: RTL and testbench



---
 rtl/clk_div_scheduler.sv | 157 +++++++++++++++
 tb/tb_clk_div_scheduler.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_div_scheduler.sv
// Shared prescaler that feeds N_CH power-of-two clock dividers and tick enables.
// Channels are retuned one at a time, and a change only lands on a period boundary.
module clk_div_scheduler #(
   parameter  int CNT_W   = 14,
   parameter  int N_CH    = 4,
   parameter  int SHIFT_W = 4,
   localparam int CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               cfg_valid,
   output logic               cfg_ready,
   input  logic [CH_W-1:0]    cfg_ch,
   input  logic [SHIFT_W-1:0] cfg_shift,
   input  logic               cfg_en,
   output logic [N_CH-1:0]    div_clk,
   output logic [N_CH-1:0]    tick,
   output logic               busy
);

   typedef enum logic [0:0] {
      IDLE    = 1'b0,
      PENDING = 1'b1
   } state_e;

   state_e             state_q;
   logic               ready_q;
   logic               busy_q;
   logic [CH_W-1:0]    pend_ch_q;
   logic [SHIFT_W-1:0] pend_shift_q;
   logic               pend_en_q;

   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [N_CH-1:0]    en_q, en_d;
   logic [N_CH-1:0]    armed_q, armed_d;
   logic [N_CH-1:0]    div_q, div_d;
   logic [N_CH-1:0]    tick_q, tick_d;
   logic [SHIFT_W-1:0] shift_q [N_CH];
   logic [SHIFT_W-1:0] shift_d [N_CH];

   logic [N_CH-1:0]    bnd_old;
   logic               bnd_new;
   logic               apply;

   // Low s bits of the counter all ones: last cycle of a 2^s period.
   function automatic logic at_boundary(input logic [CNT_W-1:0]   q,
                                        input logic [SHIFT_W-1:0] s);
      logic [CNT_W-1:0] mask;
      mask = ~({CNT_W{1'b1}} << s);
      return (q & mask) == mask;
   endfunction

   function automatic logic phase_bit(input logic [CNT_W-1:0]   q,
                                      input logic [SHIFT_W-1:0] s);
      logic [CNT_W-1:0] shifted;
      shifted = q >> (s - SHIFT_W'(1));
      return shifted[0];
   endfunction

   function automatic logic [SHIFT_W-1:0] clamp_shift(input logic [SHIFT_W-1:0] s);
      if (s == '0)
         return SHIFT_W'(1);
      else if (s > SHIFT_W'(CNT_W))
         return SHIFT_W'(CNT_W);
      else
         return s;
   endfunction

   always_comb begin
      // NOTE: every signal written here gets a default first, so no path can infer a latch.
      cnt_d   = cnt_q + CNT_W'(1);
      bnd_old = '0;
      en_d    = en_q;
      shift_d = shift_q;
      tick_d  = '0;
      div_d   = '0;

      for (int i = 0; i < N_CH; i++) begin
         bnd_old[i] = at_boundary(cnt_q, shift_q[i]);
         tick_d[i]  = en_q[i] & armed_q[i] & bnd_old[i];
         div_d[i]   = en_q[i] & armed_q[i] & phase_bit(cnt_q, shift_q[i]);
      end
      armed_d = armed_q | bnd_old;

      bnd_new = at_boundary(cnt_q, pend_shift_q);
      apply   = (state_q == PENDING) && (!en_q[pend_ch_q] || bnd_old[pend_ch_q]);

      // The outputs above still close out the old period; only the settings switch over.
      if (apply) begin
         en_d[pend_ch_q]    = pend_en_q;
         shift_d[pend_ch_q] = pend_shift_q;
         armed_d[pend_ch_q] = bnd_new;
      end
   end

   // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q   <= '0;
         en_q    <= '0;
         armed_q <= '0;
         div_q   <= '0;
         tick_q  <= '0;
         for (int i = 0; i < N_CH; i++)
            shift_q[i] <= SHIFT_W'(CNT_W);
      end else begin
         cnt_q   <= cnt_d;
         en_q    <= en_d;
         armed_q <= armed_d;
         div_q   <= div_d;
         tick_q  <= tick_d;
         shift_q <= shift_d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         ready_q      <= 1'b1;
         busy_q       <= 1'b0;
         pend_ch_q    <= '0;
         pend_shift_q <= SHIFT_W'(CNT_W);
         pend_en_q    <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (cfg_valid && ready_q) begin
                  pend_ch_q    <= cfg_ch;
                  pend_shift_q <= clamp_shift(cfg_shift);
                  pend_en_q    <= cfg_en;
                  state_q      <= PENDING;
                  ready_q      <= 1'b0;
                  busy_q       <= 1'b1;
               end
            end
            PENDING: begin
               if (apply) begin
                  state_q <= IDLE;
                  ready_q <= 1'b1;
                  busy_q  <= 1'b0;
               end
            end
            default: begin
               state_q <= IDLE;
               ready_q <= 1'b1;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign cfg_ready = ready_q;
   assign busy      = busy_q;
   assign div_clk   = div_q;
   assign tick      = tick_q;

endmodule

// File: tb/tb_clk_div_scheduler.sv
// Directed bench for clk_div_scheduler: measures high/low run lengths and tick spacing
// per channel over observation windows and compares them with hand-derived periods.
module tb_clk_div_scheduler;

   localparam int CNT_W   = 14;
   localparam int N_CH    = 4;
   localparam int SHIFT_W = 4;
   localparam int BIG     = 1 << 30;

   logic               clk = 1'b0;
   logic               rst;
   logic               cfg_valid;
   logic               cfg_ready;
   logic [1:0]         cfg_ch;
   logic [SHIFT_W-1:0] cfg_shift;
   logic               cfg_en;
   logic [N_CH-1:0]    div_clk;
   logic [N_CH-1:0]    tick;
   logic               busy;

   clk_div_scheduler #(
      .CNT_W   (CNT_W),
      .N_CH    (N_CH),
      .SHIFT_W (SHIFT_W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .cfg_valid (cfg_valid),
      .cfg_ready (cfg_ready),
      .cfg_ch    (cfg_ch),
      .cfg_shift (cfg_shift),
      .cfg_en    (cfg_en),
      .div_clk   (div_clk),
      .tick      (tick),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   // Posedges since reset release; equals the DUT prescaler value when sampled at negedge.
   int cyc;
   always @(posedge clk or posedge rst)
      if (rst) cyc <= 0;
      else     cyc <= cyc + 1;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   int hi_min [N_CH], hi_max [N_CH], hi_last [N_CH];
   int lo_min [N_CH], lo_max [N_CH];
   int tk_min [N_CH], tk_max [N_CH], tk_last [N_CH];
   int tk_cnt [N_CH], tk_wide [N_CH], tk_first [N_CH], div_on [N_CH];

   // Observe n cycles; only runs bounded by transitions on both sides are recorded.
   task automatic watch(input int n);
      int   run     [N_CH];
      bit   seen    [N_CH];
      logic prev    [N_CH];
      int   last_tk [N_CH];
      int   sp;
      for (int i = 0; i < N_CH; i++) begin
         hi_min[i] = BIG; hi_max[i] = 0; hi_last[i] = 0;
         lo_min[i] = BIG; lo_max[i] = 0;
         tk_min[i] = BIG; tk_max[i] = 0; tk_last[i] = 0;
         tk_cnt[i] = 0; tk_wide[i] = 0; tk_first[i] = -1; div_on[i] = 0;
         run[i] = 0; seen[i] = 1'b0; prev[i] = div_clk[i]; last_tk[i] = -1;
      end
      repeat (n) begin
         @(negedge clk);
         for (int i = 0; i < N_CH; i++) begin
            if (div_clk[i] === prev[i]) begin
               run[i]++;
            end else begin
               if (seen[i]) begin
                  if (prev[i] === 1'b1) begin
                     if (run[i] < hi_min[i]) hi_min[i] = run[i];
                     if (run[i] > hi_max[i]) hi_max[i] = run[i];
                     hi_last[i] = run[i];
                  end else begin
                     if (run[i] < lo_min[i]) lo_min[i] = run[i];
                     if (run[i] > lo_max[i]) lo_max[i] = run[i];
                  end
               end
               seen[i] = 1'b1;
               run[i]  = 1;
               prev[i] = div_clk[i];
            end
            if (div_clk[i] === 1'b1) div_on[i]++;
            if (tick[i] === 1'b1) begin
               tk_cnt[i]++;
               if (last_tk[i] >= 0) begin
                  sp = cyc - last_tk[i];
                  if (sp < tk_min[i]) tk_min[i] = sp;
                  if (sp > tk_max[i]) tk_max[i] = sp;
                  tk_last[i] = sp;
                  if (sp == 1) tk_wide[i]++;
               end else begin
                  tk_first[i] = cyc;
               end
               last_tk[i] = cyc;
            end
         end
      end
   endtask

   // Called at a negedge; returns at the negedge where busy is first seen low (or right after handshake).
   task automatic do_cfg(input int ch, input int sh, input bit en, input bit wait_apply,
                         output int nbusy);
      int k;
      cfg_valid = 1'b1;
      cfg_ch    = 2'(ch);
      cfg_shift = SHIFT_W'(sh);
      cfg_en    = en;
      k = 0;
      while (cfg_ready !== 1'b1 && k < 1000) begin
         @(negedge clk);
         k++;
      end
      if (k >= 1000) check("cfg_ready_timeout", k, 0);
      @(posedge clk);
      @(negedge clk);
      cfg_valid = 1'b0;
      nbusy = 0;
      if (wait_apply) begin
         while (busy === 1'b1 && nbusy < 40000) begin
            nbusy++;
            @(negedge clk);
         end
         if (nbusy >= 40000) check("apply_timeout", nbusy, 0);
      end
   endtask

   int nb;
   int dsum, tsum;
   int k;

   initial begin
      rst       = 1'b1;
      cfg_valid = 1'b0;
      cfg_ch    = '0;
      cfg_shift = '0;
      cfg_en    = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;

      // Idle after reset: everything quiet, ready for config.
      watch(100);
      dsum = 0; tsum = 0;
      for (int i = 0; i < N_CH; i++) begin dsum += div_on[i]; tsum += tk_cnt[i]; end
      check("idle_div", dsum, 0);
      check("idle_tick", tsum, 0);
      check("idle_ready", cfg_ready, 1);
      check("idle_busy", busy, 0);

      // ch0 s=3 from disabled: applied one cycle after the handshake.
      do_cfg(0, 3, 1'b1, 1'b1, nb);
      check("s3_apply_latency", nb, 1);
      watch(80);
      check("s3_hi_min", hi_min[0], 4);
      check("s3_hi_max", hi_max[0], 4);
      check("s3_lo_min", lo_min[0], 4);
      check("s3_lo_max", lo_max[0], 4);
      check("s3_tick_min", tk_min[0], 8);
      check("s3_tick_max", tk_max[0], 8);
      check("s3_tick_wide", tk_wide[0], 0);
      check("s3_tick_phase", tk_first[0] % 8, 0);

      // Retune ch0 to s=5 mid-period: held off until the s=3 boundary, no runt high phase.
      fork
         watch(120);
         begin
            repeat (8) @(negedge clk);
            k = 0;
            while (cyc % 8 != 3 && k < 16) begin @(negedge clk); k++; end
            do_cfg(0, 5, 1'b1, 1'b1, nb);
            check("s5_pending_cycles", nb, 4);
         end
      join
      check("s3to5_no_runt", hi_min[0], 4);
      watch(200);
      check("s5_hi_min", hi_min[0], 16);
      check("s5_hi_max", hi_max[0], 16);
      check("s5_lo_max", lo_max[0], 16);
      check("s5_tick_min", tk_min[0], 32);
      check("s5_tick_max", tk_max[0], 32);

      // ch2 with shift 0 behaves as s=1.
      do_cfg(2, 0, 1'b1, 1'b1, nb);
      watch(40);
      check("s0_hi_max", hi_max[2], 1);
      check("s0_lo_max", lo_max[2], 1);
      check("s0_tick_min", tk_min[2], 2);
      check("s0_tick_max", tk_max[2], 2);

      // ch1 s=4, then disable ch0: final full period with its tick, ch1 undisturbed.
      do_cfg(1, 4, 1'b1, 1'b1, nb);
      fork
         watch(200);
         begin
            repeat (37) @(negedge clk);
            do_cfg(0, 5, 1'b0, 1'b1, nb);
            check("dis_final_tick", tick[0], 1);
            check("dis_final_div_high", div_clk[0], 1);
            @(negedge clk);
            check("dis_div_low_after", div_clk[0], 0);
         end
      join
      check("dis_ch0_hi_min", hi_min[0], 16);
      check("dis_ch1_tick_min", tk_min[1], 16);
      check("dis_ch1_tick_max", tk_max[1], 16);
      watch(100);
      check("dis_ch0_div_quiet", div_on[0], 0);
      check("dis_ch0_tick_quiet", tk_cnt[0], 0);
      check("dis_ch1_tick_steady", tk_max[1], 16);

      // Longest period: ch1 s=14 and ch2 shift=15 clamped to 14.
      do_cfg(2, 0, 1'b0, 1'b1, nb);
      do_cfg(1, 14, 1'b1, 1'b1, nb);
      do_cfg(2, 15, 1'b1, 1'b1, nb);
      watch(50000);
      check("s14_ch1_hi", hi_last[1], 8192);
      check("s14_ch1_tick", tk_last[1], 16384);
      check("clamp_ch2_hi", hi_last[2], 8192);
      check("clamp_ch2_tick", tk_last[2], 16384);
      check("clamp_ch2_tick_cnt", tk_cnt[2] >= 2, 1);

      // Reset while a config is pending: outputs clear at once, the config is dropped.
      k = 0;
      while (div_clk[1] !== 1'b1 && k < 20000) begin @(negedge clk); k++; end
      do_cfg(1, 2, 1'b1, 1'b0, nb);
      check("pend_busy", busy, 1);
      #2 rst = 1'b1;
      #1;
      check("rst_async_div", div_clk, 0);
      check("rst_async_tick", tick, 0);
      check("rst_async_busy", busy, 0);
      check("rst_async_ready", cfg_ready, 1);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      watch(100);
      dsum = 0; tsum = 0;
      for (int i = 0; i < N_CH; i++) begin dsum += div_on[i]; tsum += tk_cnt[i]; end
      check("post_rst_div", dsum, 0);
      check("post_rst_tick", tsum, 0);
      check("post_rst_ready", cfg_ready, 1);
      check("post_rst_busy", busy, 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
